// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job scheduler.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        FLUSH   = 3'd5
    } sched_state_t;

    localparam int unsigned REQ_SPI   = 0;
    localparam int unsigned REQ_GPIO  = 1;
    localparam int unsigned IRQ_TMO   = 2;
    localparam int unsigned REQ_N     = 2;
    localparam int unsigned IRQ_W     = 3;
    localparam int unsigned ARM_CNT_W = 4;

    // Requester index to one-hot grant vector.
    function automatic logic [REQ_N-1:0] idx2oh(input logic idx);
        logic [REQ_N-1:0] oh;
        oh           = '0;
        oh[REQ_GPIO] = idx;
        oh[REQ_SPI]  = ~idx;
        return oh;
    endfunction

endpackage

// File: rtl/rsa_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the index that did not win last.
module rsa_rr_arb2
    import rsa_pkg::*;
(
    input  logic [REQ_N-1:0] i_req,
    input  logic             i_last,
    output logic [REQ_N-1:0] o_gnt,
    output logic             o_valid
);

    always_comb begin
        o_gnt   = i_req;
        o_valid = |i_req;
        if (&i_req) begin
            o_gnt = idx2oh(~i_last);
        end
    end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one rsa_unit between SPI and GPIO: arbitration, enable/clear sequencing,
// watchdog, abort and sticky interrupt status.
module rsa_job_scheduler
    import rsa_pkg::*;
#(
    parameter int unsigned TMO_W      = 16,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] abort,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic             eoc_rsa,
    output logic             en_rsa,
    output logic             clear_rsa,
    output logic [REQ_N-1:0] grant,
    output logic             busy,
    output logic [REQ_N-1:0] done,
    output logic [IRQ_W-1:0] irq_status,
    input  logic [IRQ_W-1:0] irq_ack,
    output logic             irq
);

    sched_state_t         r_state;
    logic [ARM_CNT_W-1:0] r_arm_cnt;
    logic [TMO_W-1:0]     r_cnt;
    logic                 r_owner;
    logic                 r_rr;
    logic                 r_en;
    logic                 r_clear;
    logic                 r_busy;
    logic                 r_irq;
    logic [REQ_N-1:0]     r_grant;
    logic [REQ_N-1:0]     r_done;
    logic [IRQ_W-1:0]     r_status;

    logic [REQ_N-1:0]     w_gnt;
    logic                 w_valid;
    logic                 w_abort_own;
    logic                 w_tmo_hit;
    logic [IRQ_W-1:0]     w_set;
    logic [IRQ_W-1:0]     w_stat_nxt;

    // r_rr holds the index that has priority on a tie; the arbiter wants the last winner.
    rsa_rr_arb2 u_arb (
        .i_req   (req),
        .i_last  (~r_rr),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    assign w_abort_own = abort[r_owner];
    assign w_tmo_hit   = (tmo_limit != '0) && (r_cnt == tmo_limit - TMO_W'(1));

    // Status set sources; a set beats an ack on the same bit.
    always_comb begin
        w_set = '0;
        if (r_state == DONE) begin
            w_set[{1'b0, r_owner}] = 1'b1;
        end
        if ((r_state == RUN) && !w_abort_own && !eoc_rsa && w_tmo_hit) begin
            w_set[IRQ_TMO] = 1'b1;
        end
        w_stat_nxt = (r_status & ~irq_ack) | w_set;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= IDLE;
            r_arm_cnt <= '0;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_rr      <= 1'b0;
            r_en      <= 1'b0;
            r_clear   <= 1'b0;
            r_busy    <= 1'b0;
            r_irq     <= 1'b0;
            r_grant   <= '0;
            r_done    <= '0;
            r_status  <= '0;
        end else if (ena) begin
            r_status <= w_stat_nxt;
            r_irq    <= |w_stat_nxt;
            r_done   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state   <= ARM;
                        r_owner   <= w_gnt[REQ_GPIO];
                        r_grant   <= w_gnt;
                        r_en      <= 1'b1;
                        r_clear   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_arm_cnt <= '0;
                    end
                end
                ARM: begin
                    if (w_abort_own) begin
                        r_state <= FLUSH;
                        r_en    <= 1'b0;
                        r_clear <= 1'b0;
                    end else if (r_arm_cnt == ARM_CNT_W'(CLR_CYCLES - 1)) begin
                        r_state <= RELEASE;
                        r_clear <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (w_abort_own) begin
                        r_state <= FLUSH;
                        r_en    <= 1'b0;
                        r_clear <= 1'b0;
                    end else begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_abort_own || (!eoc_rsa && w_tmo_hit)) begin
                        r_state <= FLUSH;
                        r_en    <= 1'b0;
                        r_clear <= 1'b0;
                    end else if (eoc_rsa) begin
                        r_state <= DONE;
                        r_done  <= idx2oh(r_owner);
                    end else if (r_cnt != {TMO_W{1'b1}}) begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                DONE, FLUSH: begin
                    r_rr    <= ~r_owner;
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_clear <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_clear <= 1'b0;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                    r_done  <= '0;
                end
            endcase
        end
    end

    assign en_rsa     = r_en;
    assign clear_rsa  = r_clear;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign done       = r_done;
    assign irq_status = r_status;
    assign irq        = r_irq;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Self-checking bench for rsa_job_scheduler: job table, done scoreboard, corner sequences.
module tb_rsa_job_scheduler;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [1:0]  req;
    logic [1:0]  abort;
    logic [15:0] tmo_limit;
    logic        eoc_rsa;
    logic [2:0]  irq_ack;

    logic        en_rsa, clear_rsa, busy, irq;
    logic [1:0]  grant, done;
    logic [2:0]  irq_status;
    logic        en_b, clear_b, busy_b, irq_b;
    logic [1:0]  grant_b, done_b;
    logic [2:0]  status_b;

    int n_chk  = 0;
    int n_fail = 0;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    rsa_job_scheduler #(.TMO_W(16), .CLR_CYCLES(1)) u_dut (
        .clk(clk), .rstb(rstb), .ena(ena), .req(req), .abort(abort),
        .tmo_limit(tmo_limit), .eoc_rsa(eoc_rsa), .en_rsa(en_rsa),
        .clear_rsa(clear_rsa), .grant(grant), .busy(busy), .done(done),
        .irq_status(irq_status), .irq_ack(irq_ack), .irq(irq)
    );

    rsa_job_scheduler #(.TMO_W(16), .CLR_CYCLES(3)) u_dut3 (
        .clk(clk), .rstb(rstb), .ena(ena), .req(req), .abort(abort),
        .tmo_limit(tmo_limit), .eoc_rsa(eoc_rsa), .en_rsa(en_b),
        .clear_rsa(clear_b), .grant(grant_b), .busy(busy_b), .done(done_b),
        .irq_status(status_b), .irq_ack(irq_ack), .irq(irq_b)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  gnt;
        int          eoc_at;
        logic [1:0]  abt;
        int          abt_at;
        logic [15:0] tmo;
        logic [2:0]  stat;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must match the oldest expected owner.
    always @(negedge clk) begin
        if (rstb && done !== 2'b00) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got %0h expected none at %0t", done, $time);
            end else begin
                logic [1:0] e;
                e = sb_q.pop_front();
                if (done !== e) begin
                    n_fail++;
                    $display("FAIL sb_done: got %0h expected %0h at %0t", done, e, $time);
                end
            end
        end
    end

    task automatic run_job(input int idx);
        vec_t v;
        int   e_ab, e_eoc, e_tmo, k_end;
        bit   is_done;
        v     = tbl[idx];
        e_ab  = (((v.abt & v.gnt) != 2'b00) && v.abt_at >= 0) ? v.abt_at : 1000;
        e_eoc = (v.eoc_at >= 0) ? v.eoc_at : 1000;
        e_tmo = (v.tmo != 16'd0) ? int'(v.tmo) - 1 : 1000;
        k_end = e_ab;
        if (e_eoc < k_end) k_end = e_eoc;
        if (e_tmo < k_end) k_end = e_tmo;
        if (k_end > 50) k_end = 50;
        is_done = (e_eoc == k_end) && (e_ab > k_end);

        req       = v.req;
        tmo_limit = v.tmo;
        if (is_done) sb_q.push_back(v.gnt);
        step();
        chk($sformatf("j%0d_grant", idx), 32'(grant), 32'(v.gnt));
        chk($sformatf("j%0d_arm_en", idx), 32'(en_rsa), 32'd1);
        chk($sformatf("j%0d_arm_clr", idx), 32'(clear_rsa), 32'd0);
        req = 2'b00;
        step();
        chk($sformatf("j%0d_rel_clr", idx), 32'(clear_rsa), 32'd1);
        step();
        for (int k = 0; k <= k_end; k++) begin
            eoc_rsa = (k == v.eoc_at);
            abort   = (k == v.abt_at) ? v.abt : 2'b00;
            step();
            eoc_rsa = 1'b0;
            abort   = 2'b00;
            if (k < k_end) begin
                chk($sformatf("j%0d_run%0d_en", idx, k), 32'(en_rsa), 32'd1);
            end else if (is_done) begin
                chk($sformatf("j%0d_done", idx), 32'(done), 32'(v.gnt));
                chk($sformatf("j%0d_done_clr", idx), 32'(clear_rsa), 32'd1);
            end else begin
                chk($sformatf("j%0d_flush_en", idx), 32'(en_rsa), 32'd0);
                chk($sformatf("j%0d_flush_clr", idx), 32'(clear_rsa), 32'd0);
                chk($sformatf("j%0d_flush_busy", idx), 32'(busy), 32'd1);
            end
        end
        step();
        chk($sformatf("j%0d_idle_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("j%0d_idle_grant", idx), 32'(grant), 32'd0);
        chk($sformatf("j%0d_stat", idx), 32'(irq_status), 32'(v.stat));
        chk($sformatf("j%0d_irq", idx), 32'(irq), 32'(|v.stat));
        irq_ack = 3'b111;
        step();
        irq_ack = 3'b000;
        chk($sformatf("j%0d_acked", idx), 32'(irq_status), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b01, 2'b01,  4, 2'b00, -1, 16'd0, 3'b001};
        tbl[1] = '{2'b10, 2'b10,  2, 2'b00, -1, 16'd0, 3'b010};
        tbl[2] = '{2'b01, 2'b01, -1, 2'b00, -1, 16'd4, 3'b100};
        tbl[3] = '{2'b10, 2'b10,  3, 2'b01,  1, 16'd0, 3'b010};
        tbl[4] = '{2'b10, 2'b10, -1, 2'b10,  2, 16'd0, 3'b000};
        tbl[5] = '{2'b10, 2'b10,  2, 2'b10,  2, 16'd0, 3'b000};
        tbl[6] = '{2'b01, 2'b01,  2, 2'b00, -1, 16'd3, 3'b001};
        tbl[7] = '{2'b01, 2'b01, -1, 2'b01,  0, 16'd1, 3'b000};
        tbl[8] = '{2'b01, 2'b01,  1, 2'b00, -1, 16'd5, 3'b001};
        tbl[9] = '{2'b10, 2'b10,  3, 2'b00, -1, 16'd2, 3'b100};

        rstb = 1'b1; ena = 1'b1; req = 2'b00; abort = 2'b00;
        tmo_limit = 16'd0; eoc_rsa = 1'b0; irq_ack = 3'b000;
        #1 rstb = 1'b0;
        #11;
        chk("rst_en", 32'(en_rsa), 32'd0);
        chk("rst_clr", 32'(clear_rsa), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stat", 32'(irq_status), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rstb = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_job(i);

        // Tie held across two jobs alternates owners.
        req = 2'b11; tmo_limit = 16'd0;
        sb_q.push_back(2'b01);
        sb_q.push_back(2'b10);
        step();
        chk("tie1_grant", 32'(grant), 32'h1);
        step(); step();
        eoc_rsa = 1'b1; step(); eoc_rsa = 1'b0;
        chk("tie1_done", 32'(done), 32'h1);
        step();
        chk("tie_idle_busy", 32'(busy), 32'd0);
        step();
        chk("tie2_grant", 32'(grant), 32'h2);
        req = 2'b00;
        step(); step();
        eoc_rsa = 1'b1; step(); eoc_rsa = 1'b0;
        step();
        chk("tie_stat", 32'(irq_status), 32'h3);
        irq_ack = 3'b011; step(); irq_ack = 3'b000;
        chk("tie_irq_cleared", 32'(irq), 32'd0);

        // Abort while still in ARM.
        req = 2'b01; step();
        chk("abarm_en", 32'(en_rsa), 32'd1);
        req = 2'b00; abort = 2'b01; step(); abort = 2'b00;
        chk("abarm_flush_en", 32'(en_rsa), 32'd0);
        chk("abarm_flush_busy", 32'(busy), 32'd1);
        step();
        chk("abarm_idle", 32'(busy), 32'd0);
        chk("abarm_stat", 32'(irq_status), 32'd0);

        // ena low mid-RUN freezes state and watchdog; eoc during freeze is ignored.
        req = 2'b10; tmo_limit = 16'd6;
        sb_q.push_back(2'b10);
        step(); req = 2'b00;
        step(); step(); step(); step();
        ena = 1'b0; eoc_rsa = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz%0d_en", i), 32'(en_rsa), 32'd1);
            chk($sformatf("frz%0d_done", i), 32'(done), 32'd0);
        end
        ena = 1'b1; eoc_rsa = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz_run%0d_en", i), 32'(en_rsa), 32'd1);
        end
        eoc_rsa = 1'b1; step(); eoc_rsa = 1'b0;
        chk("frz_done", 32'(done), 32'h2);
        step();
        chk("frz_stat", 32'(irq_status), 32'h2);

        // Ack during DONE: own bit stays set, other acked bit clears.
        req = 2'b01; tmo_limit = 16'd0;
        sb_q.push_back(2'b01);
        step(); req = 2'b00;
        step(); step();
        eoc_rsa = 1'b1; step(); eoc_rsa = 1'b0;
        chk("clash_done", 32'(done), 32'h1);
        irq_ack = 3'b011; step(); irq_ack = 3'b000;
        chk("clash_stat", 32'(irq_status), 32'h1);
        chk("clash_irq", 32'(irq), 32'd1);

        // Asynchronous reset in RUN.
        req = 2'b01; step(); req = 2'b00;
        step(); step();
        chk("prerst_en", 32'(en_rsa), 32'd1);
        rstb = 1'b0;
        #1;
        chk("arst_en", 32'(en_rsa), 32'd0);
        chk("arst_clr", 32'(clear_rsa), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stat", 32'(irq_status), 32'd0);
        #2 rstb = 1'b1;
        step();

        // CLR_CYCLES=3 instance: ARM lasts exactly three cycles.
        req = 2'b01; step(); req = 2'b00;
        chk("clr3_arm1_en", 32'(en_b), 32'd1);
        chk("clr3_arm1_clr", 32'(clear_b), 32'd0);
        step();
        chk("clr3_arm2_clr", 32'(clear_b), 32'd0);
        step();
        chk("clr3_arm3_clr", 32'(clear_b), 32'd0);
        step();
        chk("clr3_rel_clr", 32'(clear_b), 32'd1);
        abort = 2'b01; step(); abort = 2'b00;
        chk("clr3_flush_en", 32'(en_b), 32'd0);
        chk("clr1_flush_en", 32'(en_rsa), 32'd0);
        step();
        chk("clr3_idle", 32'(busy_b), 32'd0);
        chk("clr1_idle", 32'(busy), 32'd0);

        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
